gpr_regfile_sb: RTL and testbench

- Parametrised successor to the single-write GPR file for the OoO issue stage.
- Provides NumRead read ports and NumWrite write ports, with x0 hard-wired to zero.
- Adds a per-register scoreboard: a busy bit plus a producer tag, set at dispatch and cleared on tag-matched writeback.
- Issue logic reads operand values together with readiness/tag in one cycle; flush clears all pending producers.

---
 rtl/ysyx_24080006_pkg.sv | 10 +
 rtl/gpr_regfile_sb_if.sv | 37 +++
 rtl/gpr_scoreboard.sv | 78 +++++++
 rtl/gpr_regfile_sb.sv | 87 ++++++++
 tb/tb_gpr_regfile_sb.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24080006_pkg.sv
// Shared core constants and types: register index width and ROB tag width.
package ysyx_24080006_pkg;

  localparam int RegWidth = 5;
  localparam int TagWidth = 4;

  typedef logic [RegWidth-1:0] gpr_addr_t;
  typedef logic [TagWidth-1:0] rob_tag_t;

endpackage

// File: rtl/gpr_regfile_sb_if.sv
// Read, write-back, dispatch-allocate and flush bundle of the GPR file with scoreboard.
interface gpr_regfile_sb_if
  import ysyx_24080006_pkg::*;
#(
  parameter int NumRead   = 2,
  parameter int NumWrite  = 2,
  parameter int DataWidth = 32,
  parameter int AddrWidth = RegWidth,
  parameter int TagWidth  = ysyx_24080006_pkg::TagWidth
);

  logic [NumRead-1:0][AddrWidth-1:0]  raddr;
  logic [NumRead-1:0][DataWidth-1:0]  rdata;
  logic [NumRead-1:0]                 rbusy;
  logic [NumRead-1:0][TagWidth-1:0]   rtag;

  logic [NumWrite-1:0]                we;
  logic [NumWrite-1:0][AddrWidth-1:0] waddr;
  logic [NumWrite-1:0][DataWidth-1:0] wdata;
  logic [NumWrite-1:0][TagWidth-1:0]  wtag;

  logic                               alloc_valid;
  logic [AddrWidth-1:0]               alloc_addr;
  logic [TagWidth-1:0]                alloc_tag;
  logic                               flush;

  modport master (
    output raddr, we, waddr, wdata, wtag, alloc_valid, alloc_addr, alloc_tag, flush,
    input  rdata, rbusy, rtag
  );

  modport slave (
    input  raddr, we, waddr, wdata, wtag, alloc_valid, alloc_addr, alloc_tag, flush,
    output rdata, rbusy, rtag
  );

endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register busy bit and producer tag; priority flush > alloc > tag-matched clear.
// With GPR_BYPASS_EN the per-port clear-match vector is exported for read bypass.
module gpr_scoreboard
  import ysyx_24080006_pkg::*;
#(
  parameter int NumRead   = 2,
  parameter int NumWrite  = 2,
  parameter int AddrWidth = RegWidth,
  parameter int TagWidth  = ysyx_24080006_pkg::TagWidth
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NumWrite-1:0]                we_i,
  input  logic [NumWrite-1:0][AddrWidth-1:0] waddr_i,
  input  logic [NumWrite-1:0][TagWidth-1:0]  wtag_i,
  input  logic                               alloc_valid_i,
  input  logic [AddrWidth-1:0]               alloc_addr_i,
  input  logic [TagWidth-1:0]                alloc_tag_i,
  input  logic                               flush_i,
  input  logic [NumRead-1:0][AddrWidth-1:0]  raddr_i,
  output logic [NumRead-1:0]                 rbusy_o,
`ifdef GPR_BYPASS_EN
  output logic [NumWrite-1:0]                wclr_o,
`endif
  output logic [NumRead-1:0][TagWidth-1:0]   rtag_o
);

  localparam int Depth = 1 << AddrWidth;

  logic [Depth-1:0]               busy_q, busy_d;
  logic [Depth-1:0][TagWidth-1:0] tag_q, tag_d;
  logic [NumWrite-1:0]            clr_hit;

  // A writeback only retires the producer the register is still waiting on.
  always_comb begin
    for (int p = 0; p < NumWrite; p++) begin
      clr_hit[p] = we_i[p] && (waddr_i[p] != '0) && busy_q[waddr_i[p]]
                   && (tag_q[waddr_i[p]] == wtag_i[p]);
    end
  end

  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    for (int p = 0; p < NumWrite; p++) begin
      if (clr_hit[p]) busy_d[waddr_i[p]] = 1'b0;
    end
    if (flush_i) begin
      busy_d = '0;
    end else if (alloc_valid_i && (alloc_addr_i != '0)) begin
      busy_d[alloc_addr_i] = 1'b1;
      tag_d[alloc_addr_i]  = alloc_tag_i;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  // Entry 0 is never allocated, so x0 reads busy=0, tag=0 naturally.
  always_comb begin
    for (int i = 0; i < NumRead; i++) begin
      rbusy_o[i] = busy_q[raddr_i[i]];
      rtag_o[i]  = tag_q[raddr_i[i]];
    end
  end

`ifdef GPR_BYPASS_EN
  assign wclr_o = clr_hit;
`endif

endmodule

// File: rtl/gpr_regfile_sb.sv
// Multi-port GPR file (x0 = 0) with per-register producer scoreboard; writes land next edge.
// Optional GPR_BYPASS_EN forwards same-cycle write data (and matched clears) to the read ports.
module gpr_regfile_sb
  import ysyx_24080006_pkg::*;
#(
  parameter int NumRead   = 2,
  parameter int NumWrite  = 2,
  parameter int DataWidth = 32,
  parameter int AddrWidth = RegWidth,
  parameter int TagWidth  = ysyx_24080006_pkg::TagWidth
) (
  input logic             clock,
  input logic             reset,
  gpr_regfile_sb_if.slave bus
);

  localparam int Depth = 1 << AddrWidth;

  logic [Depth-1:0][DataWidth-1:0] data_q, data_d;
  logic [NumRead-1:0]              sb_busy;

  // Ascending port order lets the highest-index writer win on a collision.
  always_comb begin
    data_d = data_q;
    for (int p = 0; p < NumWrite; p++) begin
      if (bus.we[p] && (bus.waddr[p] != '0)) data_d[bus.waddr[p]] = bus.wdata[p];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) data_q <= '0;
    else        data_q <= data_d;
  end

`ifdef GPR_BYPASS_EN
  logic [NumWrite-1:0] wclr;
  logic [NumRead-1:0]  alloc_hit;
`endif

  gpr_scoreboard #(
    .NumRead   (NumRead),
    .NumWrite  (NumWrite),
    .AddrWidth (AddrWidth),
    .TagWidth  (TagWidth)
  ) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .we_i          (bus.we),
    .waddr_i       (bus.waddr),
    .wtag_i        (bus.wtag),
    .alloc_valid_i (bus.alloc_valid),
    .alloc_addr_i  (bus.alloc_addr),
    .alloc_tag_i   (bus.alloc_tag),
    .flush_i       (bus.flush),
    .raddr_i       (bus.raddr),
    .rbusy_o       (sb_busy),
`ifdef GPR_BYPASS_EN
    .wclr_o        (wclr),
`endif
    .rtag_o        (bus.rtag)
  );

`ifdef GPR_BYPASS_EN
  // A same-cycle re-allocation keeps the register busy even if its old producer retires.
  always_comb begin
    for (int i = 0; i < NumRead; i++) begin
      alloc_hit[i] = bus.alloc_valid && !bus.flush && (bus.alloc_addr == bus.raddr[i]);
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < NumRead; i++) begin
      bus.rdata[i] = data_q[bus.raddr[i]];
      bus.rbusy[i] = sb_busy[i];
`ifdef GPR_BYPASS_EN
      for (int p = 0; p < NumWrite; p++) begin
        if (bus.we[p] && (bus.waddr[p] == bus.raddr[i]) && (bus.raddr[i] != '0)) begin
          bus.rdata[i] = bus.wdata[p];
          bus.rbusy[i] = (wclr[p] && !alloc_hit[i]) ? 1'b0 : sb_busy[i];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_gpr_regfile_sb.sv
// Scoreboard bench for gpr_regfile_sb: directed scenarios then random traffic vs an array model.
module tb_gpr_regfile_sb;
  import ysyx_24080006_pkg::*;

  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DW = 32;
  localparam int AW = RegWidth;
  localparam int TW = TagWidth;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  gpr_regfile_sb_if bus ();

  gpr_regfile_sb dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Staged stimulus, applied to the DUT at the next falling edge.
  logic                       s_rst;
  logic [NR-1:0][AW-1:0]      s_raddr;
  logic [NW-1:0]              s_we;
  logic [NW-1:0][AW-1:0]      s_waddr;
  logic [NW-1:0][DW-1:0]      s_wdata;
  logic [NW-1:0][TW-1:0]      s_wtag;
  logic                       s_alloc_valid;
  logic [AW-1:0]              s_alloc_addr;
  logic [TW-1:0]              s_alloc_tag;
  logic                       s_flush;

  // Reference model: architectural view of register values and pending producers.
  logic [DW-1:0] m_reg  [DEPTH];
  logic          m_busy [DEPTH];
  logic [TW-1:0] m_tag  [DEPTH];

  typedef struct packed {
    logic [NR-1:0][AW-1:0] a;
    logic [NR-1:0][DW-1:0] d;
    logic [NR-1:0]         b;
    logic [NR-1:0][TW-1:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int port, input int addr,
                       input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s port%0d x%0d got=%h want=%h", name, port, addr, got, want);
  endtask

  task automatic idle();
    s_rst = 1'b1;
    s_we = '0;
    s_waddr = '0;
    s_wdata = '0;
    s_wtag = '0;
    s_alloc_valid = 1'b0;
    s_alloc_addr = '0;
    s_alloc_tag = '0;
    s_flush = 1'b0;
  endtask

  task automatic model_update();
    logic nb [DEPTH];
    if (!s_rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_reg[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) nb[r] = m_busy[r];
      for (int p = 0; p < NW; p++) begin
        if (s_we[p] && s_waddr[p] != 0) begin
          if (m_busy[s_waddr[p]] && m_tag[s_waddr[p]] == s_wtag[p]) nb[s_waddr[p]] = 1'b0;
        end
      end
      for (int p = 0; p < NW; p++) begin
        if (s_we[p] && s_waddr[p] != 0) m_reg[s_waddr[p]] = s_wdata[p];
      end
      if (s_flush) begin
        for (int r = 0; r < DEPTH; r++) nb[r] = 1'b0;
      end else if (s_alloc_valid && s_alloc_addr != 0) begin
        nb[s_alloc_addr] = 1'b1;
        m_tag[s_alloc_addr] = s_alloc_tag;
      end
      for (int r = 0; r < DEPTH; r++) m_busy[r] = nb[r];
    end
  endtask

  task automatic step();
    exp_t e;
    int   hp;
    int   a;
    @(negedge clock);
    reset           = s_rst;
    bus.raddr       = s_raddr;
    bus.we          = s_we;
    bus.waddr       = s_waddr;
    bus.wdata       = s_wdata;
    bus.wtag        = s_wtag;
    bus.alloc_valid = s_alloc_valid;
    bus.alloc_addr  = s_alloc_addr;
    bus.alloc_tag   = s_alloc_tag;
    bus.flush       = s_flush;
    if (s_rst) begin
      for (int i = 0; i < NR; i++) begin
        a = int'(s_raddr[i]);
        e.a[i] = s_raddr[i];
        e.d[i] = m_reg[a];
        e.b[i] = m_busy[a];
        e.t[i] = m_tag[a];
`ifdef GPR_BYPASS_EN
        hp = -1;
        for (int p = 0; p < NW; p++) begin
          if (s_we[p] && int'(s_waddr[p]) == a && a != 0) hp = p;
        end
        if (hp >= 0) begin
          e.d[i] = s_wdata[hp];
          if (m_busy[a] && m_tag[a] == s_wtag[hp]
              && !(s_alloc_valid && !s_flush && int'(s_alloc_addr) == a)) e.b[i] = 1'b0;
        end
`else
        hp = 0;
`endif
      end
      exp_q.push_back(e);
    end
    model_update();
  endtask

  // Monitor: compares whatever expectations the driver queued this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NR; i++) begin
          check("rdata", i, int'(e.a[i]), bus.rdata[i], e.d[i]);
          check("rbusy", i, int'(e.a[i]), 32'(bus.rbusy[i]), 32'(e.b[i]));
          check("rtag",  i, int'(e.a[i]), 32'(bus.rtag[i]),  32'(e.t[i]));
        end
      end
    end
  end

  initial begin
    for (int r = 0; r < DEPTH; r++) begin
      m_reg[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
    end
    idle();
    s_raddr = '0;

    // Reset with write/alloc traffic that must be ignored.
    s_rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_we = 2'b11;
      s_waddr[0] = AW'($urandom_range(1, DEPTH - 1));
      s_waddr[1] = AW'($urandom_range(1, DEPTH - 1));
      s_wdata[0] = $urandom;
      s_wdata[1] = $urandom;
      s_alloc_valid = 1'b1;
      s_alloc_addr = AW'($urandom_range(1, DEPTH - 1));
      s_alloc_tag = TW'($urandom);
      step();
    end
    idle();
    for (int k = 0; k < DEPTH / 2; k++) begin
      s_raddr[0] = AW'(2 * k);
      s_raddr[1] = AW'(2 * k + 1);
      step();
    end

    idle(); s_we[0] = 1'b1; s_waddr[0] = 5; s_wdata[0] = 32'hDEADBEEF; s_raddr = '0; step();
    idle(); s_raddr[0] = 5; step();

    // Same-address collision, then write to x0.
    idle(); s_we = 2'b11; s_waddr[0] = 7; s_waddr[1] = 7;
    s_wdata[0] = 32'h11; s_wdata[1] = 32'h22; step();
    idle(); s_we[0] = 1'b1; s_waddr[0] = 0; s_wdata[0] = 32'hFFFFFFFF;
    s_raddr[0] = 7; s_raddr[1] = 0; step();
    idle(); step();

    // Allocate then matched writeback.
    idle(); s_alloc_valid = 1'b1; s_alloc_addr = 3; s_alloc_tag = 4; s_raddr[0] = 3; step();
    idle(); s_we[0] = 1'b1; s_waddr[0] = 3; s_wdata[0] = 32'h55; s_wtag[0] = 4; step();
    idle(); step();

    // Re-allocation makes the old producer stale.
    idle(); s_alloc_valid = 1'b1; s_alloc_addr = 3; s_alloc_tag = 4; step();
    idle(); s_alloc_valid = 1'b1; s_alloc_addr = 3; s_alloc_tag = 9; step();
    idle(); s_we[1] = 1'b1; s_waddr[1] = 3; s_wdata[1] = 32'h66; s_wtag[1] = 4; step();
    idle(); step();
    idle(); s_we[0] = 1'b1; s_waddr[0] = 3; s_wdata[0] = 32'h77; s_wtag[0] = 9; step();
    idle(); step();

    // Alloc beats matched clear; flush beats alloc.
    idle(); s_alloc_valid = 1'b1; s_alloc_addr = 8; s_alloc_tag = 2; s_raddr[0] = 8; step();
    idle(); s_alloc_valid = 1'b1; s_alloc_addr = 8; s_alloc_tag = 2;
    s_we[0] = 1'b1; s_waddr[0] = 8; s_wdata[0] = 32'hA8; s_wtag[0] = 2; step();
    idle(); step();
    idle(); s_flush = 1'b1; s_alloc_valid = 1'b1; s_alloc_addr = 9; s_alloc_tag = 5;
    s_we[1] = 1'b1; s_waddr[1] = 9; s_wdata[1] = 32'h99; s_raddr[1] = 9; step();
    idle(); step();

    // Same-cycle write and read of x10.
    idle(); s_we[0] = 1'b1; s_waddr[0] = 10; s_wdata[0] = 32'h1234; s_raddr[0] = 10; step();
    idle(); step();

    // Random traffic, biased toward a few registers so tags collide and clear.
    for (int n = 0; n < 1500; n++) begin
      s_rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NR; i++) begin
        s_raddr[i] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      end
      for (int p = 0; p < NW; p++) begin
        s_we[p] = ($urandom_range(0, 2) == 0);
        s_waddr[p] = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        s_wdata[p] = $urandom;
        s_wtag[p] = ($urandom_range(0, 1) == 1) ? m_tag[s_waddr[p]] : TW'($urandom);
      end
      s_alloc_valid = ($urandom_range(0, 2) == 0);
      s_alloc_addr = AW'($urandom_range(0, 7));
      s_alloc_tag = TW'($urandom);
      s_flush = ($urandom_range(0, 29) == 0);
      step();
    end

    idle(); step();
    repeat (2) @(negedge clock);
    #4;
    check("drain", 0, 0, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
